// File: rtl/flow_key_dispatcher.sv
// Buffers parsed {src_ip, dst_ip} flow keys and deals them round-robin to the
// sketch-update lanes, with an epoch drain/report sequence for the readout side.
module flow_key_dispatcher #(
    parameter int FIFO_DEPTH = 16,
    parameter int NUM_LANES  = 4,
    parameter int KEY_W      = 64
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        i_key_valid,
    input  logic [31:0]                 i_src_ip,
    input  logic [31:0]                 i_dst_ip,
    output logic [NUM_LANES-1:0]        o_lane_valid,
    output logic [KEY_W-1:0]            o_lane_key,
    input  logic [NUM_LANES-1:0]        i_lane_ready,
    input  logic                        i_epoch_req,
    output logic                        o_epoch_done,
    output logic                        o_busy,
    output logic [$clog2(FIFO_DEPTH):0] o_fifo_level,
    output logic [31:0]                 o_pkt_cnt,
    output logic [31:0]                 o_drop_cnt
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

    typedef enum logic [1:0] {S_RUN, S_DRAIN, S_DONE} state_t;

    state_t             r_state;
    logic [KEY_W-1:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0]      r_wr_ptr;
    logic [AW-1:0]      r_rd_ptr;
    logic [AW:0]        r_count;
    logic [NUM_LANES-1:0] r_lane_valid;
    logic [KEY_W-1:0]   r_lane_key;
    logic [LW-1:0]      r_rr_ptr;
    logic               r_epoch_done;
    logic [31:0]        r_pkt_cnt;
    logic [31:0]        r_drop_cnt;

    logic               w_full;
    logic               w_empty;
    logic               w_wr;
    logic               w_rd;
    logic               w_drop;
    logic               w_slot_free;
    logic               w_found;
    logic [LW-1:0]      w_sel;
    logic [LW-1:0]      w_rr_next;
    int                 w_idx;

    assign w_full      = (r_count == (AW+1)'(FIFO_DEPTH));
    assign w_empty     = (r_count == '0);
    assign w_wr        = i_key_valid && (r_state == S_RUN) && !w_full;
    assign w_drop      = i_key_valid && (r_state != S_DONE) && !w_wr;
    assign w_slot_free = (r_lane_valid == '0) || ((r_lane_valid & i_lane_ready) != '0);
    assign w_rd        = w_slot_free && !w_empty && w_found;
    assign w_rr_next   = (w_sel == LW'(NUM_LANES - 1)) ? '0 : w_sel + 1'b1;

    // Find the first ready lane at or after the round-robin pointer, wrapping.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_idx   = 0;
        for (int k = 0; k < NUM_LANES; k++) begin
            w_idx = (int'(r_rr_ptr) + k) % NUM_LANES;
            if (!w_found && i_lane_ready[w_idx]) begin
                w_found = 1'b1;
                w_sel   = LW'(w_idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= {i_src_ip, i_dst_ip};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // An offer, once made, is held for its own lane until that lane takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lane_valid <= '0;
            r_lane_key   <= '0;
            r_rr_ptr     <= '0;
        end else if (w_slot_free) begin
            if (w_rd) begin
                r_lane_valid <= NUM_LANES'(1) << w_sel;
                r_lane_key   <= r_mem[r_rd_ptr];
                r_rr_ptr     <= w_rr_next;
            end else begin
                r_lane_valid <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_RUN;
            r_epoch_done <= 1'b0;
            r_pkt_cnt    <= '0;
            r_drop_cnt   <= '0;
        end else begin
            if (w_wr && r_pkt_cnt != 32'hFFFF_FFFF)
                r_pkt_cnt <= r_pkt_cnt + 1'b1;
            if (w_drop && r_drop_cnt != 32'hFFFF_FFFF)
                r_drop_cnt <= r_drop_cnt + 1'b1;
            case (r_state)
                S_RUN: begin
                    if (i_epoch_req) r_state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (w_empty && r_lane_valid == '0) begin
                        r_state      <= S_DONE;
                        r_epoch_done <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state      <= S_RUN;
                    r_epoch_done <= 1'b0;
                    r_pkt_cnt    <= '0;
                    r_drop_cnt   <= '0;
                end
                default: r_state <= S_RUN;
            endcase
        end
    end

    assign o_lane_valid = r_lane_valid;
    assign o_lane_key   = r_lane_key;
    assign o_epoch_done = r_epoch_done;
    assign o_busy       = !w_empty || (r_lane_valid != '0);
    assign o_fifo_level = r_count;
    assign o_pkt_cnt    = r_pkt_cnt;
    assign o_drop_cnt   = r_drop_cnt;

endmodule

// File: tb/tb_flow_key_dispatcher.sv
// Directed self-checking bench for flow_key_dispatcher (FIFO_DEPTH=16, NUM_LANES=4).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_flow_key_dispatcher;

    logic        clk;
    logic        rst_n;
    logic        keyValid;
    logic [31:0] srcIp;
    logic [31:0] dstIp;
    logic [3:0]  laneValid;
    logic [63:0] laneKey;
    logic [3:0]  laneReady;
    logic        epochReq;
    logic        epochDone;
    logic        busy;
    logic [4:0]  fifoLevel;
    logic [31:0] pktCnt;
    logic [31:0] dropCnt;

    int assertCount = 0;
    int failCount   = 0;

    flow_key_dispatcher #(.FIFO_DEPTH(16), .NUM_LANES(4), .KEY_W(64)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_key_valid  (keyValid),
        .i_src_ip     (srcIp),
        .i_dst_ip     (dstIp),
        .o_lane_valid (laneValid),
        .o_lane_key   (laneKey),
        .i_lane_ready (laneReady),
        .i_epoch_req  (epochReq),
        .o_epoch_done (epochDone),
        .o_busy       (busy),
        .o_fifo_level (fifoLevel),
        .o_pkt_cnt    (pktCnt),
        .o_drop_cnt   (dropCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs, then return at the next falling edge.
    task automatic applyStimulus(input logic kv, input logic [31:0] src, input logic [31:0] dst,
                                 input logic [3:0] ready, input logic ereq);
        keyValid  = kv;
        srcIp     = src;
        dstIp     = dst;
        laneReady = ready;
        epochReq  = ereq;
        @(negedge clk);
    endtask

    task automatic doReset();
        rst_n     = 1'b0;
        keyValid  = 1'b0;
        srcIp     = '0;
        dstIp     = '0;
        laneReady = '0;
        epochReq  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [63:0] keyOf(input int n);
        return {32'h0A00_0000 + 32'(n), 32'h0B00_0000 + 32'(n)};
    endfunction

    initial begin
        int offers;
        int dones;
        logic prevDone;

        // Reset values
        doReset();
        checkOutput("reset_lane_valid", 64'(laneValid), 64'h0);
        checkOutput("reset_lane_key", laneKey, 64'h0);
        checkOutput("reset_fifo_level", 64'(fifoLevel), 64'h0);
        checkOutput("reset_busy", 64'(busy), 64'h0);
        checkOutput("reset_epoch_done", 64'(epochDone), 64'h0);
        checkOutput("reset_pkt_cnt", 64'(pktCnt), 64'h0);

        // Single key, two-cycle latency to lane 0
        applyStimulus(1'b1, 32'hC0A8_010A, 32'hC0A8_0114, 4'hF, 1'b0);
        checkOutput("single_level", 64'(fifoLevel), 64'h1);
        checkOutput("single_pkt_cnt", 64'(pktCnt), 64'h1);
        checkOutput("single_not_yet", 64'(laneValid), 64'h0);
        applyStimulus(1'b0, 32'h0, 32'h0, 4'hF, 1'b0);
        checkOutput("single_lane_valid", 64'(laneValid), 64'h1);
        checkOutput("single_lane_key", laneKey, 64'hC0A8_010A_C0A8_0114);
        checkOutput("single_busy", 64'(busy), 64'h1);
        applyStimulus(1'b0, 32'h0, 32'h0, 4'hF, 1'b0);
        checkOutput("single_granted", 64'(laneValid), 64'h0);

        // Eight keys back-to-back, all lanes ready
        doReset();
        for (int k = 0; k < 10; k++) begin
            logic [63:0] key;
            key = keyOf(k);
            applyStimulus(k < 8, key[63:32], key[31:0], 4'hF, 1'b0);
            if (k >= 1 && k <= 8) begin
                checkOutput($sformatf("b2b_lane_%0d", k-1), 64'(laneValid), 64'(4'b0001 << ((k-1) % 4)));
                checkOutput($sformatf("b2b_key_%0d", k-1), laneKey, keyOf(k-1));
            end
        end
        checkOutput("b2b_level", 64'(fifoLevel), 64'h0);
        checkOutput("b2b_idle", 64'(laneValid), 64'h0);
        checkOutput("b2b_pkt_cnt", 64'(pktCnt), 64'h8);

        // Only lane 2 ready; offer holds while it stalls
        doReset();
        for (int k = 0; k < 3; k++) begin
            logic [63:0] key;
            key = keyOf(k + 20);
            applyStimulus(1'b1, key[63:32], key[31:0], (k < 2) ? 4'b0100 : 4'b0000, 1'b0);
        end
        checkOutput("lane2_first", 64'(laneValid), 64'h4);
        checkOutput("lane2_first_key", laneKey, keyOf(20));
        checkOutput("lane2_level", 64'(fifoLevel), 64'h2);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b0, 32'h0, 32'h0, 4'b0000, 1'b0);
            checkOutput($sformatf("lane2_hold_valid_%0d", k), 64'(laneValid), 64'h4);
            checkOutput($sformatf("lane2_hold_key_%0d", k), laneKey, keyOf(20));
        end
        for (int k = 1; k < 3; k++) begin
            applyStimulus(1'b0, 32'h0, 32'h0, 4'b0100, 1'b0);
            checkOutput($sformatf("lane2_next_valid_%0d", k), 64'(laneValid), 64'h4);
            checkOutput($sformatf("lane2_next_key_%0d", k), laneKey, keyOf(20 + k));
        end
        applyStimulus(1'b0, 32'h0, 32'h0, 4'b0100, 1'b0);
        checkOutput("lane2_done", 64'(laneValid), 64'h0);

        // Overflow: 20 keys into a 16-deep FIFO with no lane ready
        doReset();
        for (int k = 0; k < 20; k++) begin
            logic [63:0] key;
            key = keyOf(k + 40);
            applyStimulus(1'b1, key[63:32], key[31:0], 4'h0, 1'b0);
        end
        checkOutput("ovf_level", 64'(fifoLevel), 64'd16);
        checkOutput("ovf_pkt_cnt", 64'(pktCnt), 64'd16);
        checkOutput("ovf_drop_cnt", 64'(dropCnt), 64'd4);
        checkOutput("ovf_no_offer", 64'(laneValid), 64'h0);
        for (int k = 0; k < 16; k++) begin
            applyStimulus(1'b0, 32'h0, 32'h0, 4'hF, 1'b0);
            checkOutput($sformatf("ovf_drain_lane_%0d", k), 64'(laneValid), 64'(4'b0001 << (k % 4)));
            checkOutput($sformatf("ovf_drain_key_%0d", k), laneKey, keyOf(k + 40));
        end
        applyStimulus(1'b0, 32'h0, 32'h0, 4'hF, 1'b0);
        checkOutput("ovf_drained_level", 64'(fifoLevel), 64'h0);
        checkOutput("ovf_drained_busy", 64'(busy), 64'h0);

        // Epoch with nothing buffered: done two cycles after the request
        doReset();
        applyStimulus(1'b0, 32'h0, 32'h0, 4'hF, 1'b1);
        checkOutput("epoch_empty_drain", 64'(epochDone), 64'h0);
        applyStimulus(1'b0, 32'h0, 32'h0, 4'hF, 1'b0);
        checkOutput("epoch_empty_done", 64'(epochDone), 64'h1);
        applyStimulus(1'b1, 32'h1111_1111, 32'h2222_2222, 4'hF, 1'b0);
        checkOutput("epoch_done_key_pkt", 64'(pktCnt), 64'h0);
        checkOutput("epoch_done_key_drop", 64'(dropCnt), 64'h0);
        checkOutput("epoch_done_key_level", 64'(fifoLevel), 64'h0);
        checkOutput("epoch_done_cleared", 64'(epochDone), 64'h0);

        // Epoch with five buffered keys and two arrivals during the drain
        doReset();
        for (int k = 0; k < 5; k++) begin
            logic [63:0] key;
            key = keyOf(k + 60);
            applyStimulus(1'b1, key[63:32], key[31:0], 4'h0, 1'b0);
        end
        applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
        applyStimulus(1'b1, 32'h3333_3333, 32'h4444_4444, 4'h0, 1'b1);
        applyStimulus(1'b1, 32'h5555_5555, 32'h6666_6666, 4'h0, 1'b0);
        checkOutput("drain_level", 64'(fifoLevel), 64'd5);
        checkOutput("drain_drop_cnt", 64'(dropCnt), 64'd2);
        offers   = 0;
        dones    = 0;
        prevDone = 1'b0;
        for (int k = 0; k < 15; k++) begin
            applyStimulus(1'b0, 32'h0, 32'h0, 4'hF, 1'b0);
            if (prevDone) begin
                checkOutput("post_epoch_pkt_cnt", 64'(pktCnt), 64'h0);
                checkOutput("post_epoch_drop_cnt", 64'(dropCnt), 64'h0);
            end
            if (laneValid != 4'h0) begin
                checkOutput($sformatf("drain_key_%0d", offers), laneKey, keyOf(offers + 60));
                offers++;
            end
            if (epochDone) begin
                dones++;
                checkOutput("epoch_pkt_cnt", 64'(pktCnt), 64'd5);
                checkOutput("epoch_drop_cnt", 64'(dropCnt), 64'd2);
            end
            prevDone = epochDone;
        end
        checkOutput("drain_offers", 64'(offers), 64'd5);
        checkOutput("epoch_done_pulses", 64'(dones), 64'd1);

        // Asynchronous reset with keys buffered and an offer pending on lane 1
        doReset();
        for (int k = 0; k < 6; k++) begin
            logic [63:0] key;
            key = keyOf(k + 80);
            applyStimulus(1'b1, key[63:32], key[31:0], 4'h0, 1'b0);
        end
        applyStimulus(1'b0, 32'h0, 32'h0, 4'b0010, 1'b0);
        laneReady = 4'h0;
        checkOutput("pre_rst_lane_valid", 64'(laneValid), 64'h2);
        checkOutput("pre_rst_level", 64'(fifoLevel), 64'd5);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_lane_valid", 64'(laneValid), 64'h0);
        checkOutput("async_rst_level", 64'(fifoLevel), 64'h0);
        checkOutput("async_rst_pkt_cnt", 64'(pktCnt), 64'h0);
        checkOutput("async_rst_busy", 64'(busy), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput("post_rst_level", 64'(fifoLevel), 64'h0);
        applyStimulus(1'b1, 32'hAAAA_0001, 32'hBBBB_0002, 4'hF, 1'b0);
        applyStimulus(1'b0, 32'h0, 32'h0, 4'hF, 1'b0);
        checkOutput("post_rst_lane", 64'(laneValid), 64'h1);
        checkOutput("post_rst_key", laneKey, 64'hAAAA_0001_BBBB_0002);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/flow_key_dispatcher.md
Name: flow_key_dispatcher

Overview:
- Takes the per-packet flow key produced by the GMII UDP/IP header parser: a one-cycle done pulse plus the source and destination IPv4 addresses.
- Buffers keys in a small FIFO and distributes them round-robin to NUM_LANES sketch-update engines using a valid/ready handshake.
- Provides measurement-epoch control: on request it drains all buffered keys, then reports accepted and dropped packet counts to the PCIe readout logic.

Parameters:
FIFO_DEPTH, 16, key FIFO entries; power of 2, 4..256.
NUM_LANES, 4, number of update-engine lanes, 1..8.
KEY_W, 64, key width; fixed to 64 ({src_ip, dst_ip}).

Ports:
clk  in  1  clock.
rst_n  in  1  asynchronous active-low reset.
key_valid  in  1  one-cycle pulse per parsed packet (parser done strobe).
src_ip  in  32  source IP, valid when key_valid=1.
dst_ip  in  32  destination IP, valid when key_valid=1.
lane_valid  out  NUM_LANES  one-hot; key offered to lane i.
lane_key  out  KEY_W  shared key bus to all lanes.
lane_ready  in  NUM_LANES  lane i can accept a key this cycle.
epoch_req  in  1  one-cycle pulse: end the current epoch.
epoch_done  out  1  one-cycle pulse: drain complete, counters valid.
busy  out  1  1 when the FIFO is non-empty or any lane_valid bit is set.
fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
pkt_cnt  out  32  keys accepted in the current epoch.
drop_cnt  out  32  keys dropped in the current epoch.

Behaviour:
- Clock and reset: clk with rst_n, asynchronous, active-low.
- Reset values: all outputs 0; FIFO empty; round-robin pointer 0; state S_RUN. Assertion of reset mid-operation discards all buffered keys and any pending offer.
- Key packing: lane_key = {src_ip, dst_ip}, with src_ip in bits [63:32].
- Key acceptance: key_valid=1 in S_RUN and FIFO not full at the start of the cycle -> key written and pkt_cnt+1.
  - A key arriving while the FIFO is full is dropped and counted in drop_cnt (drop_cnt+1).
  - A read in the same cycle does not free space for that write; there is no bypass.
- Key arriving outside S_RUN: dropped and drop_cnt+1.
- Counters: both saturate at 32'hFFFF_FFFF.
- FIFO: show-ahead with registered pointers. A simultaneous write and read when neither full nor empty leaves fifo_level unchanged.
- Dispatch output stage (registered):
  - The offer slot is free when lane_valid==0, or when it was granted this cycle ((lane_valid & lane_ready)!=0).
  - When the slot is free and the FIFO is non-empty, select the first lane with lane_ready=1, searching from rr_ptr upward and wrapping modulo NUM_LANES.
  - On selection: pop the FIFO; load lane_key; set the one-hot lane_valid; rr_ptr = selected+1 (mod NUM_LANES).
  - If no lane is ready, nothing is popped and lane_valid stays 0.
  - Once asserted, lane_valid and lane_key hold unchanged until that lane's ready is 1. The offer is never retargeted.
  - Back-to-back transfers: a grant and a new load can occur in the same cycle, giving one key per cycle throughput.
- Latency: key_valid at cycle t with the FIFO empty and a lane ready -> lane_valid high at cycle t+2.
- State machine:
  - S_RUN: normal operation. epoch_req -> S_DRAIN.
  - S_DRAIN: no new keys accepted; dispatch continues. FIFO empty and lane_valid==0 -> S_DONE.
  - S_DONE: one cycle. epoch_done=1; pkt_cnt and drop_cnt hold this epoch's final values. Next cycle -> S_RUN with both counters cleared to 0.
    - A key_valid in this S_DONE cycle is dropped and is not counted in either epoch.
- epoch_req while in S_DRAIN or S_DONE is ignored.
- epoch_req with the FIFO empty and no pending offer: S_RUN -> S_DRAIN -> S_DONE, so epoch_done asserts 2 cycles after epoch_req.
- busy is combinational from the FIFO empty flag and lane_valid.

Test Plan:
- Reset, then a single key (src=C0A8010A, dst=C0A80114) with all lanes ready -> two cycles later lane_valid=0001, lane_key=C0A8010A_C0A80114; pkt_cnt=1.
- 8 keys back-to-back, lane_ready=1111 -> grants go to lanes 0,1,2,3,0,1,2,3, one per cycle; fifo_level returns to 0.
- lane_ready=0100 only, 3 keys -> all three go to lane 2; lane_valid stays 0100 and the key holds stable while lane_ready is deasserted for 5 cycles.
- lane_ready=0000, 20 keys (FIFO_DEPTH=16) -> fifo_level=16, pkt_cnt=16, drop_cnt=4; then ready=1111 drains all 16 in order.
- 5 keys buffered, lanes stalled, epoch_req; 2 more keys during S_DRAIN; then ready=1111 -> 5 keys dispatched, epoch_done pulses once with pkt_cnt=5, drop_cnt=2; next cycle both counters are 0.
- Reset asserted with 6 buffered keys and lane_valid=0010 -> outputs go to 0 immediately (asynchronously); after release, fifo_level=0 and the first new key goes to lane 0.
